// File: rtl/apb_master_bridge_pkg.sv
// Shared types and helpers for the APB master bridge.
// The optional wait-state timeout is enabled with the APB_TIMEOUT_EN macro.
package apb_master_pkg;

  // FSM encoding of the APB3 transfer phases
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

  // Width of the wait-state counter so it can represent 0..cycles
  function automatic int unsigned tmo_cnt_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus signals of the bridge, bundled in one interface.
// master: the bridge view; slave: requester plus APB slave view (the environment).
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // local requester side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  // APB side
  logic [ADDR_W-1:0] P_addr;
  logic              P_selx;
  logic              P_enable;
  logic              P_write;
  logic [DATA_W-1:0] P_wdata;
  logic              P_ready;
  logic              P_slverr;
  logic [DATA_W-1:0] P_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, P_ready, P_slverr, P_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr,
           P_addr, P_selx, P_enable, P_write, P_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, P_ready, P_slverr, P_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr,
           P_addr, P_selx, P_enable, P_write, P_wdata
  );
endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// ACCESS wait-state counter. Cleared on the way into ACCESS, counts wait cycles,
// and flags the cycle that is the TIMEOUT_CYCLES-th wait cycle.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);
  localparam int unsigned     CNT_W = tmo_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear wins, saturate at the limit so it never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                    cnt_d = '0;
    else if (inc_i && cnt_q != LAST) cnt_d = cnt_q + CNT_W'(1);
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // count holds the number of wait cycles already completed in this ACCESS
  assign expired_o = (cnt_q == LAST);
endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: one command in, one IDLE->SETUP->ACCESS transfer out, one response
// pulse back. Single transfer outstanding. All bus/response outputs registered.
// Optional ACCESS timeout: define APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 P_clk,
  input  logic                 P_rst,
  apb_master_bridge_if.master  bus
);
  apb_state_e        state_q;
  logic [ADDR_W-1:0] P_addr_q;
  logic              P_selx_q;
  logic              P_enable_q;
  logic              P_write_q;
  logic [DATA_W-1:0] P_wdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_slverr_q;
  logic              tmo_expired;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_TIMEOUT_EN
  // SETUP always precedes ACCESS, so clearing there restarts the count on entry
  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk_i     (P_clk),
    .rst_ni    (P_rst),
    .clear_i   (state_q == ST_SETUP),
    .inc_i     ((state_q == ST_ACCESS) && !bus.P_ready),
    .expired_o (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // transfer FSM with registered APB and response outputs
  always_ff @(posedge P_clk) begin
    if (!P_rst) begin
      state_q      <= ST_IDLE;
      P_addr_q     <= '0;
      P_selx_q     <= 1'b0;
      P_enable_q   <= 1'b0;
      P_write_q    <= 1'b0;
      P_wdata_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            P_addr_q  <= bus.cmd_addr;
            P_write_q <= bus.cmd_write;
            P_wdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
            P_selx_q  <= 1'b1;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          P_enable_q <= 1'b1;
          state_q    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // a ready slave on the limit cycle still completes normally
          if (bus.P_ready) begin
            P_selx_q     <= 1'b0;
            P_enable_q   <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_slverr_q <= bus.P_slverr;
            rsp_rdata_q  <= P_write_q ? '0 : bus.P_rdata;
            state_q      <= ST_IDLE;
          end else if (tmo_expired) begin
            P_selx_q     <= 1'b0;
            P_enable_q   <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_slverr_q <= 1'b1;
            rsp_rdata_q  <= '0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          P_selx_q   <= 1'b0;
          P_enable_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_slverr = rsp_slverr_q;
  assign bus.P_addr     = P_addr_q;
  assign bus.P_selx     = P_selx_q;
  assign bus.P_enable   = P_enable_q;
  assign bus.P_write    = P_write_q;
  assign bus.P_wdata    = P_wdata_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: reset, write, read with waits, slave error,
// back-to-back, reset mid-ACCESS and (with APB_TIMEOUT_EN) timeout.
module tb_apb_master_bridge;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
    .P_clk (clk),
    .P_rst (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // advance one edge; outputs settle and inputs change 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset cmd_ready got %b want 1", bus.cmd_ready); end
    checks++; if (bus.P_selx !== 1'b0 || bus.P_enable !== 1'b0) begin fails++; $display("FAIL reset sel/en got %b%b want 00", bus.P_selx, bus.P_enable); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_slverr !== 1'b0) begin fails++; $display("FAIL reset rsp got %b%b want 00", bus.rsp_valid, bus.rsp_slverr); end
    checks++; if (bus.P_addr !== 32'h0 || bus.P_wdata !== 32'h0 || bus.rsp_rdata !== 32'h0 || bus.P_write !== 1'b0) begin fails++; $display("FAIL reset data got a=%h w=%h r=%h want 0", bus.P_addr, bus.P_wdata, bus.rsp_rdata); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_nowait();
    bus.P_ready = 1'b1;
    issue(1'b1, 32'h04, 32'hDEADBEEF);
    tick();  // SETUP
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.P_selx, bus.P_enable, bus.P_write, bus.cmd_ready} !== 4'b1010) begin fails++; $display("FAIL wr setup ctl got %b want 1010", {bus.P_selx, bus.P_enable, bus.P_write, bus.cmd_ready}); end
    checks++; if (bus.P_addr !== 32'h04 || bus.P_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr setup data got %h/%h want 00000004/deadbeef", bus.P_addr, bus.P_wdata); end
    tick();  // ACCESS
    checks++; if ({bus.P_selx, bus.P_enable, bus.rsp_valid} !== 3'b110) begin fails++; $display("FAIL wr access got %b want 110", {bus.P_selx, bus.P_enable, bus.rsp_valid}); end
    checks++; if (bus.P_addr !== 32'h04 || bus.P_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr access data got %h/%h want 00000004/deadbeef", bus.P_addr, bus.P_wdata); end
    tick();  // response, 3 cycles after accept
    checks++; if ({bus.rsp_valid, bus.rsp_slverr, bus.cmd_ready, bus.P_selx, bus.P_enable} !== 5'b10100) begin fails++; $display("FAIL wr rsp got %b want 10100", {bus.rsp_valid, bus.rsp_slverr, bus.cmd_ready, bus.P_selx, bus.P_enable}); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin fails++; $display("FAIL wr rsp_rdata got %h want 0", bus.rsp_rdata); end
    checks++; if (bus.P_addr !== 32'h04 || bus.P_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr idle hold got %h/%h want 00000004/deadbeef", bus.P_addr, bus.P_wdata); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL wr rsp pulse got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_read_wait();
    bus.P_ready = 1'b0;
    bus.P_rdata = 32'hBAD0BAD0;
    issue(1'b0, 32'h10, 32'hFFFF_FFFF);
    tick();  // SETUP
    bus.cmd_valid = 1'b0;
    checks++; if (bus.P_write !== 1'b0 || bus.P_wdata !== 32'h0) begin fails++; $display("FAIL rd setup got w=%b wdata=%h want 0/0", bus.P_write, bus.P_wdata); end
    for (int k = 1; k <= 3; k++) begin
      tick();  // ACCESS k
      checks++; if ({bus.P_selx, bus.P_enable, bus.rsp_valid} !== 3'b110 || bus.P_addr !== 32'h10) begin fails++; $display("FAIL rd access%0d got %b addr=%h want 110 addr=00000010", k, {bus.P_selx, bus.P_enable, bus.rsp_valid}, bus.P_addr); end
    end
    bus.P_ready = 1'b1;
    bus.P_rdata = 32'h12345678;
    tick();
    bus.P_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h12345678 || bus.rsp_slverr !== 1'b0) begin fails++; $display("FAIL rd rsp got v=%b d=%h e=%b want 1/12345678/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_slverr); end
  endtask

  task automatic test_slverr();
    bus.P_ready  = 1'b1;
    bus.P_slverr = 1'b1;
    bus.P_rdata  = 32'hA5A5A5A5;
    issue(1'b0, 32'h20, 32'h0);
    tick();  // SETUP
    bus.cmd_valid = 1'b0;
    tick();  // ACCESS
    issue(1'b1, 32'h30, 32'h55);
    tick();  // response cycle, new command accepted on the next edge
    bus.P_slverr = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_slverr, bus.cmd_ready} !== 3'b111 || bus.rsp_rdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL err rsp got %b d=%h want 111 d=a5a5a5a5", {bus.rsp_valid, bus.rsp_slverr, bus.cmd_ready}, bus.rsp_rdata); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.P_selx, bus.P_enable, bus.rsp_valid} !== 3'b100 || bus.P_addr !== 32'h30 || bus.P_wdata !== 32'h55) begin fails++; $display("FAIL err next setup got %b a=%h w=%h want 100 a=30 w=55", {bus.P_selx, bus.P_enable, bus.rsp_valid}, bus.P_addr, bus.P_wdata); end
    tick(); tick();
    checks++; if ({bus.rsp_valid, bus.rsp_slverr} !== 2'b10 || bus.rsp_rdata !== 32'h0) begin fails++; $display("FAIL err next rsp got %b d=%h want 10 d=0", {bus.rsp_valid, bus.rsp_slverr}, bus.rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    bus.P_ready = 1'b1;
    bus.P_rdata = 32'hCAFEF00D;
    tick();
    issue(1'b0, 32'h100, 32'h0);
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp_v = (t == 3 || t == 6 || t == 9);
      checks++; if (bus.rsp_valid !== exp_v) begin fails++; $display("FAIL b2b rsp_valid t=%0d got %b want %b", t, bus.rsp_valid, exp_v); end
      if (exp_v) begin
        checks++; if (bus.rsp_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL b2b rdata t=%0d got %h want cafef00d", t, bus.rsp_rdata); end
      end
      if (t == 4) begin
        checks++; if (bus.P_addr !== 32'h104 || bus.P_selx !== 1'b1) begin fails++; $display("FAIL b2b 2nd addr got %h sel=%b want 00000104 1", bus.P_addr, bus.P_selx); end
      end
      if (t == 1) bus.cmd_addr = 32'h104;
      if (t == 4) bus.cmd_addr = 32'h108;
      if (t == 7) bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_access();
    bus.P_ready = 1'b0;
    issue(1'b0, 32'h40, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    checks++; if (bus.P_enable !== 1'b1) begin fails++; $display("FAIL rst-mid in access got en=%b want 1", bus.P_enable); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if ({bus.P_selx, bus.P_enable, bus.rsp_valid, bus.cmd_ready} !== 4'b0001) begin fails++; $display("FAIL rst-mid abort got %b want 0001", {bus.P_selx, bus.P_enable, bus.rsp_valid, bus.cmd_ready}); end
    bus.P_ready = 1'b1;
    tick();
    checks++; if ({bus.P_selx, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin fails++; $display("FAIL rst-mid after got %b want 001", {bus.P_selx, bus.rsp_valid, bus.cmd_ready}); end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    bus.P_ready  = 1'b0;
    bus.P_slverr = 1'b0;
    bus.P_rdata  = 32'h99999999;
    issue(1'b0, 32'h50, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if ({bus.P_enable, bus.rsp_valid} !== 2'b10) begin fails++; $display("FAIL tmo access%0d got %b want 10", k, {bus.P_enable, bus.rsp_valid}); end
    end
    tick();
    checks++; if ({bus.rsp_valid, bus.rsp_slverr, bus.cmd_ready, bus.P_selx} !== 4'b1110 || bus.rsp_rdata !== 32'h0) begin fails++; $display("FAIL tmo rsp got %b d=%h want 1110 d=0", {bus.rsp_valid, bus.rsp_slverr, bus.cmd_ready, bus.P_selx}, bus.rsp_rdata); end
    // ready on the limit cycle completes normally
    issue(1'b0, 32'h54, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick(); tick(); tick(); tick();
    bus.P_ready = 1'b1;
    bus.P_rdata = 32'h77;
    tick();
    checks++; if ({bus.rsp_valid, bus.rsp_slverr} !== 2'b10 || bus.rsp_rdata !== 32'h77) begin fails++; $display("FAIL tmo race got %b d=%h want 10 d=77", {bus.rsp_valid, bus.rsp_slverr}, bus.rsp_rdata); end
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.P_ready   = 1'b0;
    bus.P_slverr  = 1'b0;
    bus.P_rdata   = '0;
    test_reset();
    test_write_nowait();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_reset_mid_access();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
